// File: rtl/alu_pkg.sv
// Shared opcode and ALU function-word definitions for the ALU issue path.
// The function word is {subtract, bool1, bool0, shft, math}.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOR  = 4'd5,
      OP_SLL  = 4'd6,
      OP_SRL  = 4'd7,
      OP_SRA  = 4'd8,
      OP_SLT  = 4'd9,
      OP_SLTU = 4'd10
   } alu_op_t;

   localparam int unsigned FN_W = 5;

   localparam logic [FN_W-1:0] FN_ADD  = 5'b00001;
   localparam logic [FN_W-1:0] FN_SUB  = 5'b10001;
   localparam logic [FN_W-1:0] FN_AND  = 5'b00000;
   localparam logic [FN_W-1:0] FN_OR   = 5'b00100;
   localparam logic [FN_W-1:0] FN_XOR  = 5'b01000;
   localparam logic [FN_W-1:0] FN_NOR  = 5'b01100;
   localparam logic [FN_W-1:0] FN_SLL  = 5'b00010;
   localparam logic [FN_W-1:0] FN_SRL  = 5'b01010;
   localparam logic [FN_W-1:0] FN_SRA  = 5'b01110;
   localparam logic [FN_W-1:0] FN_SLT  = 5'b10011;
   localparam logic [FN_W-1:0] FN_SLTU = 5'b10111;

   // Returns {fn, illegal}; unknown opcodes fall back to ADD with illegal set.
   function automatic logic [FN_W:0] alu_fn_encode(input alu_op_t op);
      logic [FN_W-1:0] fn;
      logic            illegal;
      fn      = FN_ADD;
      illegal = 1'b0;
      case (op)
         OP_ADD:  fn = FN_ADD;
         OP_SUB:  fn = FN_SUB;
         OP_AND:  fn = FN_AND;
         OP_OR:   fn = FN_OR;
         OP_XOR:  fn = FN_XOR;
         OP_NOR:  fn = FN_NOR;
         OP_SLL:  fn = FN_SLL;
         OP_SRL:  fn = FN_SRL;
         OP_SRA:  fn = FN_SRA;
         OP_SLT:  fn = FN_SLT;
         OP_SLTU: fn = FN_SLTU;
         default: begin
            fn      = FN_ADD;
            illegal = 1'b1;
         end
      endcase
      return {fn, illegal};
   endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Circular response buffer: head entry is presented combinationally,
// push and pop in the same cycle leave the occupancy unchanged.
module rsp_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head,
   output logic             valid
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push && (count_q != DEPTH_C);
      do_pop   = pop && (count_q != '0);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_next(rd_ptr_q);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];
   assign valid = (count_q != '0);

endmodule

// File: rtl/alu_issue_unit.sv
// Issue side of a combinational ALU: registers operands/function word,
// captures the result into a credit-protected response FIFO.
module alu_issue_unit
   import alu_pkg::*;
#(
   parameter int unsigned N          = 32,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned TAG_W      = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [N-1:0]     cmd_a,
   input  logic [N-1:0]     cmd_b,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [N-1:0]     alu_A,
   output logic [N-1:0]     alu_B,
   output logic [4:0]       alu_fn,
   input  logic [N-1:0]     alu_R,
   input  logic             alu_FlagZ,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [N-1:0]     rsp_r,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [15:0]      ops_done
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned ENT_W = N + TAG_W + 2;
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [N-1:0]     r;
      logic             zero;
      logic [TAG_W-1:0] tag;
      logic             err;
   } rsp_ent_t;

   logic             s1_valid_q, s1_valid_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic [FN_W-1:0]  fn_q, fn_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             err_q, err_d;
   logic [15:0]      ops_done_q, ops_done_d;

   logic [FN_W:0]    enc;
   logic             accept;
   logic             pop;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   occ;
   rsp_ent_t         push_ent;
   rsp_ent_t         head_ent;
   logic [ENT_W-1:0] head_bits;

   assign enc    = alu_fn_encode(alu_op_t'(cmd_op));
   assign pop    = rsp_valid && rsp_ready;
   assign occ    = {1'b0, fifo_count} + (CNT_W + 1)'(s1_valid_q);
   // A same-cycle pop frees a slot, so it may return a credit immediately.
   assign cmd_ready = (occ < DEPTH_L) || pop;
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      s1_valid_d = 1'b0;
      a_d        = a_q;
      b_d        = b_q;
      fn_d       = fn_q;
      tag_d      = tag_q;
      err_d      = err_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         a_d        = cmd_a;
         b_d        = cmd_b;
         fn_d       = enc[FN_W:1];
         tag_d      = cmd_tag;
         err_d      = enc[0];
      end
   end

   always_comb begin
      ops_done_d = ops_done_q;
      if (pop) begin
         ops_done_d = ops_done_q + 16'd1;
      end
   end

   always_comb begin
      push_ent.r    = err_q ? '0 : alu_R;
      push_ent.zero = !err_q && alu_FlagZ;
      push_ent.tag  = tag_q;
      push_ent.err  = err_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         fn_q       <= '0;
         tag_q      <= '0;
         err_q      <= 1'b0;
         ops_done_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         a_q        <= a_d;
         b_q        <= b_d;
         fn_q       <= fn_d;
         tag_q      <= tag_d;
         err_q      <= err_d;
         ops_done_q <= ops_done_d;
      end
   end

   rsp_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (s1_valid_q),
      .push_data (push_ent),
      .pop       (pop),
      .count     (fifo_count),
      .head      (head_bits),
      .valid     (rsp_valid)
   );

   assign head_ent = rsp_ent_t'(head_bits);

   assign alu_A    = a_q;
   assign alu_B    = b_q;
   assign alu_fn   = fn_q;
   assign rsp_r    = head_ent.r;
   assign rsp_zero = head_ent.zero;
   assign rsp_err  = head_ent.err;
   assign rsp_tag  = head_ent.tag;
   assign ops_done = ops_done_q;

endmodule
